// File: rtl/draw_pkg.sv
// Shared screen geometry, image selects and sequencer state encoding
// for the full-screen blit and object plot path.
package draw_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam int XW = 8;
    localparam int YW = 7;
    localparam int AW = 15;
    localparam int CW = 3;

    localparam logic [1:0] IMG_BLACK = 2'd0;
    localparam logic [1:0] IMG_RED   = 2'd1;
    localparam logic [1:0] IMG_TITLE = 2'd2;
    localparam logic [1:0] IMG_OVER  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/raster_counter.sv
// Raster scan counter: x/y position and linear ROM address,
// with x wrap into y and a flag on the final pixel address.
module raster_counter
    import draw_pkg::*;
#(
    parameter int WIDTH  = SCREEN_W,
    parameter int HEIGHT = SCREEN_H
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_i,
    input  logic          step_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic [AW-1:0] addr_o,
    output logic          last_o
);

    localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);
    localparam logic [AW-1:0] A_MAX = AW'(WIDTH * HEIGHT - 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [AW-1:0] addr_q, addr_d;

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        addr_d = addr_q;
        if (clear_i) begin
            x_d    = '0;
            y_d    = '0;
            addr_d = '0;
        end else if (step_i) begin
            addr_d = addr_q + AW'(1);
            if (x_q == X_MAX) begin
                x_d = '0;
                y_d = y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            addr_q <= addr_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign addr_o = addr_q;
    assign last_o = (addr_q == A_MAX);

endmodule

// File: rtl/screen_sequencer.sv
// Full-screen image blitter into the VGA write port, sharing the port
// with single-pixel object requests whenever no blit is running.
module screen_sequencer
    import draw_pkg::*;
#(
    parameter int WIDTH  = SCREEN_W,
    parameter int HEIGHT = SCREEN_H
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    sel,
    output logic          busy,
    output logic          done,
    output logic [1:0]    rom_sel,
    output logic [AW-1:0] rom_addr,
    input  logic [CW-1:0] rom_q,
    input  logic          obj_req,
    input  logic [XW-1:0] obj_x,
    input  logic [YW-1:0] obj_y,
    input  logic [CW-1:0] obj_colour,
    output logic          obj_ack,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [CW-1:0] colour,
    output logic          plot
);

    state_e        state_q;
    logic          busy_q;
    logic          drain_q;
    logic [1:0]    rom_sel_q;

    logic [XW-1:0] cnt_x;
    logic [YW-1:0] cnt_y;
    logic          cnt_last;
    logic          cnt_clear;
    logic          cnt_step;

    logic          v1_q;
    logic          last1_q;
    logic [XW-1:0] x1_q;
    logic [YW-1:0] y1_q;

    logic          plot_q;
    logic          done_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic [CW-1:0] colour_q;
    logic          obj_in_range;

    assign cnt_clear = (state_q == IDLE) && start;
    assign cnt_step  = (state_q == FILL) && !cnt_last;

    raster_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_raster (
        .clk     (clk),
        .rst     (rst),
        .clear_i (cnt_clear),
        .step_i  (cnt_step),
        .x_o     (cnt_x),
        .y_o     (cnt_y),
        .addr_o  (rom_addr),
        .last_o  (cnt_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            drain_q   <= 1'b0;
            rom_sel_q <= IMG_BLACK;
        end else begin
            unique case (state_q)
                IDLE: if (start) begin
                    state_q   <= FILL;
                    busy_q    <= 1'b1;
                    rom_sel_q <= sel;
                end
                FILL: if (cnt_last) begin
                    state_q <= DRAIN;
                    drain_q <= 1'b0;
                end
                DRAIN: if (drain_q) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end else begin
                    drain_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Blit has priority: a start in the same cycle blocks the grant.
    assign obj_ack      = obj_req && (state_q == IDLE) && !start;
    assign obj_in_range = (32'(obj_x) < WIDTH) && (32'(obj_y) < HEIGHT);

    // Stage 1 waits out the ROM read; stage 2 is the write port itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q     <= 1'b0;
            last1_q  <= 1'b0;
            x1_q     <= '0;
            y1_q     <= '0;
            plot_q   <= 1'b0;
            done_q   <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
        end else begin
            v1_q    <= (state_q == FILL);
            last1_q <= cnt_last;
            x1_q    <= cnt_x;
            y1_q    <= cnt_y;
            plot_q  <= 1'b0;
            done_q  <= 1'b0;
            if (v1_q) begin
                x_q      <= x1_q;
                y_q      <= y1_q;
                colour_q <= rom_q;
                plot_q   <= 1'b1;
                done_q   <= last1_q;
            end else if (obj_ack && obj_in_range) begin
                x_q      <= obj_x;
                y_q      <= obj_y;
                colour_q <= obj_colour;
                plot_q   <= 1'b1;
            end
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rom_sel = rom_sel_q;
    assign x       = x_q;
    assign y       = y_q;
    assign colour  = colour_q;
    assign plot    = plot_q;

endmodule
